// File: rtl/instr_fetch_sequencer.sv
// -----------------------------------------------------------------------------
// instr_fetch_sequencer
//
// Instruction-fetch sequencer in front of an Avalon-MM instruction master.
// Holds the program counter, issues level requests (start_read/in_address)
// to the master, captures read_data on the master's ready pulse and presents
// each word to decode through a single-entry, stall-aware output register.
// Branch redirects are accepted at any time; a redirect that arrives while a
// transfer is outstanding marks that transfer for squashing, since an Avalon
// read cannot be aborted once issued.
//
// Optional build macro: FETCH_TIMEOUT_EN
//   Defined   -> REQ is bounded to TIMEOUT_CYCLES cycles; on expiry the
//                request is dropped, fetch_error is set (sticky) and the
//                same pc is retried after the normal gap.
//   Undefined -> REQ waits indefinitely; fetch_error is tied low.
//
// Ports:
//   clk            system clock
//   reset          synchronous, active-high reset
//   fetch_ready    one-cycle ready pulse from the master
//   fetch_data     master read data, valid with fetch_ready
//   stall          decode not accepting; holds instr_valid/instr_out
//   branch_taken   one-cycle redirect request
//   branch_target  redirect address (bits [1:0] ignored)
//   start_read     level read request to the master
//   in_address     registered fetch address to the master
//   instr_out      fetched instruction
//   pc_out         address of instr_out
//   instr_valid    instr_out/pc_out valid
//   fetch_busy     high while in REQ
//   fetch_error    sticky request-timeout flag
// -----------------------------------------------------------------------------
module instr_fetch_sequencer #(
    parameter logic [31:0] RESET_PC       = 32'h0000_0000,
    parameter int unsigned PC_STEP        = 4,
    parameter int unsigned GAP_CYCLES     = 2,
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        fetch_ready,
    input  logic [31:0] fetch_data,
    input  logic        stall,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        start_read,
    output logic [31:0] in_address,
    output logic [31:0] instr_out,
    output logic [31:0] pc_out,
    output logic        instr_valid,
    output logic        fetch_busy,
    output logic        fetch_error
);

    // state | meaning
    // ------+----------------------------------------------------------------
    // IDLE  | one cycle after reset; launches the first request
    // REQ   | start_read high, in_address stable, waiting for fetch_ready
    // GAP   | start_read low for GAP_CYCLES so the master's edge detector
    //       | re-arms; leaves only when the output register is free/consumed

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_REQ  = 2'd1,
        S_GAP  = 2'd2
    } state_t;

    // Reject illegal parameterisations at elaboration.
    if (GAP_CYCLES < 2 || GAP_CYCLES > 15) begin : g_gap_range_check
        $error("GAP_CYCLES must be in 2..15");
    end
    if (TIMEOUT_CYCLES < 1) begin : g_timeout_range_check
        $error("TIMEOUT_CYCLES must be at least 1");
    end

    // Gap timer is a down-counter; terminal count 0 marks the last gap cycle.
    localparam logic [3:0]  GAP_LOAD = 4'(GAP_CYCLES - 1);
    localparam logic [31:0] PC_INC   = 32'(PC_STEP);

    state_t      state, state_nxt;
    logic [31:0] pc, pc_nxt;
    logic [31:0] addr_nxt;
    logic        start_nxt;
    logic [31:0] instr_nxt;
    logic [31:0] pc_out_nxt;
    logic        valid_nxt;
    logic        squash, squash_nxt;
    logic [3:0]  gap_cnt, gap_nxt;
    logic [31:0] branch_pc;
    logic        consume;

`ifdef FETCH_TIMEOUT_EN
    localparam int unsigned TW       = $clog2(TIMEOUT_CYCLES + 1);
    localparam logic [TW-1:0] TMO_LOAD = TW'(TIMEOUT_CYCLES - 1);

    logic [TW-1:0] tmo_cnt, tmo_nxt;
    logic          err_nxt;
`else
    assign fetch_error = 1'b0;
`endif

    assign branch_pc  = branch_target & ~32'h3;
    assign consume    = instr_valid && !stall;
    assign fetch_busy = (state == S_REQ);

    always_comb begin
        state_nxt  = state;
        pc_nxt     = pc;
        addr_nxt   = in_address;
        start_nxt  = start_read;
        instr_nxt  = instr_out;
        pc_out_nxt = pc_out;
        valid_nxt  = instr_valid;
        squash_nxt = squash;
        gap_nxt    = gap_cnt;
`ifdef FETCH_TIMEOUT_EN
        // Held at the load value outside REQ, so every REQ entry starts fresh.
        tmo_nxt    = TMO_LOAD;
        err_nxt    = fetch_error;
`endif

        if (consume) begin
            valid_nxt = 1'b0;
        end

        case (state)
            S_IDLE: begin
                state_nxt = S_REQ;
                start_nxt = 1'b1;
                addr_nxt  = branch_taken ? branch_pc : pc;
            end

            S_REQ: begin
                if (fetch_ready) begin
                    start_nxt  = 1'b0;
                    state_nxt  = S_GAP;
                    gap_nxt    = GAP_LOAD;
                    squash_nxt = 1'b0;
                    // A squashed transfer or a redirect on the same edge drops
                    // the word; pc then comes from the branch path below.
                    if (!squash && !branch_taken) begin
                        instr_nxt  = fetch_data;
                        pc_out_nxt = pc;
                        valid_nxt  = 1'b1;
                        pc_nxt     = pc + PC_INC;
                    end
                end
`ifdef FETCH_TIMEOUT_EN
                else if (tmo_cnt == '0) begin
                    start_nxt  = 1'b0;
                    err_nxt    = 1'b1;
                    squash_nxt = 1'b0;
                    state_nxt  = S_GAP;
                    gap_nxt    = GAP_LOAD;
                end else begin
                    tmo_nxt = tmo_cnt - TW'(1);
                    if (branch_taken) begin
                        squash_nxt = 1'b1;
                    end
                end
`else
                else if (branch_taken) begin
                    squash_nxt = 1'b1;
                end
`endif
            end

            S_GAP: begin
                if (gap_cnt != 4'd0) begin
                    gap_nxt = gap_cnt - 4'd1;
                end else if (!instr_valid || !stall) begin
                    state_nxt = S_REQ;
                    start_nxt = 1'b1;
                    // A redirect on the exit edge must steer this request too.
                    addr_nxt  = branch_taken ? branch_pc : pc;
                end
            end

            default: begin
                state_nxt = S_IDLE;
                start_nxt = 1'b0;
            end
        endcase

        // Redirect wins over capture, consumption and stall.
        if (branch_taken) begin
            pc_nxt    = branch_pc;
            valid_nxt = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state       <= S_IDLE;
            pc          <= RESET_PC;
            in_address  <= RESET_PC;
            start_read  <= 1'b0;
            instr_out   <= 32'h0;
            pc_out      <= 32'h0;
            instr_valid <= 1'b0;
            squash      <= 1'b0;
            gap_cnt     <= GAP_LOAD;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt     <= TMO_LOAD;
            fetch_error <= 1'b0;
`endif
        end else begin
            state       <= state_nxt;
            pc          <= pc_nxt;
            in_address  <= addr_nxt;
            start_read  <= start_nxt;
            instr_out   <= instr_nxt;
            pc_out      <= pc_out_nxt;
            instr_valid <= valid_nxt;
            squash      <= squash_nxt;
            gap_cnt     <= gap_nxt;
`ifdef FETCH_TIMEOUT_EN
            tmo_cnt     <= tmo_nxt;
            fetch_error <= err_nxt;
`endif
        end
    end

endmodule

// File: tb/tb_instr_fetch_sequencer.sv
module tb_instr_fetch_sequencer;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        fetch_ready = 1'b0;
    logic [31:0] fetch_data = 32'h0;
    logic        stall = 1'b0;
    logic        branch_taken = 1'b0;
    logic [31:0] branch_target = 32'h0;
    logic        start_read;
    logic [31:0] in_address;
    logic [31:0] instr_out;
    logic [31:0] pc_out;
    logic        instr_valid;
    logic        fetch_busy;
    logic        fetch_error;

    int checks = 0;
    int failures = 0;

    instr_fetch_sequencer #(
        .RESET_PC      (32'h0000_0000),
        .PC_STEP       (4),
        .GAP_CYCLES    (2),
        .TIMEOUT_CYCLES(8)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .fetch_ready  (fetch_ready),
        .fetch_data   (fetch_data),
        .stall        (stall),
        .branch_taken (branch_taken),
        .branch_target(branch_target),
        .start_read   (start_read),
        .in_address   (in_address),
        .instr_out    (instr_out),
        .pc_out       (pc_out),
        .instr_valid  (instr_valid),
        .fetch_busy   (fetch_busy),
        .fetch_error  (fetch_error)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    task automatic do_reset;
        reset = 1'b1;
        fetch_ready = 1'b0;
        fetch_data = 32'h0;
        stall = 1'b0;
        branch_taken = 1'b0;
        branch_target = 32'h0;
        repeat (3) @(negedge clk);
        reset = 1'b0;
    endtask

    // Wait (bounded) for start_read high; low counts negedges seen low first.
    task automatic wait_start(input int budget, output bit ok, output int low);
        ok = 1'b0;
        low = 0;
        for (int i = 0; i < budget; i++) begin
            if (start_read === 1'b1) begin
                ok = 1'b1;
                break;
            end
            low++;
            @(negedge clk);
        end
    endtask

    // Master answer: ready pulse lat cycles after the current negedge.
    task automatic respond(input logic [31:0] data, input int lat);
        repeat (lat - 1) @(negedge clk);
        fetch_ready = 1'b1;
        fetch_data = data;
        @(negedge clk);
        fetch_ready = 1'b0;
        fetch_data = 32'hDEAD_BEEF;
    endtask

    task automatic test_reset;
        bit ok;
        int low;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        checks++; if (start_read !== 1'b0) begin failures++; $display("FAIL rst_start_read got=%b exp=0", start_read); end
        checks++; if (in_address !== 32'h0) begin failures++; $display("FAIL rst_in_address got=%h exp=00000000", in_address); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL rst_instr_valid got=%b exp=0", instr_valid); end
        checks++; if (instr_out !== 32'h0) begin failures++; $display("FAIL rst_instr_out got=%h exp=00000000", instr_out); end
        checks++; if (pc_out !== 32'h0) begin failures++; $display("FAIL rst_pc_out got=%h exp=00000000", pc_out); end
        checks++; if (fetch_error !== 1'b0) begin failures++; $display("FAIL rst_fetch_error got=%b exp=0", fetch_error); end
        checks++; if (fetch_busy !== 1'b0) begin failures++; $display("FAIL rst_fetch_busy got=%b exp=0", fetch_busy); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (start_read !== 1'b1) begin failures++; $display("FAIL idle_one_cycle start_read got=%b exp=1", start_read); end
        wait_start(20, ok, low);
        checks++; if (!ok) begin failures++; $display("FAIL rst_first_req got=timeout exp=start_read"); end
        // Reset in the middle of REQ, with a late ready that must be ignored.
        reset = 1'b1;
        @(negedge clk);
        checks++; if ({start_read, fetch_busy} !== 2'b00) begin failures++; $display("FAIL midreq_reset got=%b exp=00", {start_read, fetch_busy}); end
        reset = 1'b0;
        fetch_ready = 1'b1;
        fetch_data = 32'hBAD0_BAD0;
        @(negedge clk);
        fetch_ready = 1'b0;
        checks++; if ({instr_valid, start_read} !== 2'b01) begin failures++; $display("FAIL idle_ignores_ready got=%b exp=01", {instr_valid, start_read}); end
    endtask

    task automatic test_sequential;
        logic [31:0] d [3] = '{32'h1111_1111, 32'h2222_2222, 32'h3333_3333};
        bit ok;
        int low;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            wait_start(20, ok, low);
            checks++; if (!ok) begin failures++; $display("FAIL seq_req%0d got=timeout exp=start_read", i); end
            checks++; if (in_address !== 32'(i * 4)) begin failures++; $display("FAIL seq_addr%0d got=%h exp=%h", i, in_address, 32'(i * 4)); end
            if (i > 0) begin
                checks++; if (low < 2) begin failures++; $display("FAIL seq_gap%0d got=%0d exp>=2", i, low); end
            end
            respond(d[i], 3);
            checks++; if (instr_valid !== 1'b1) begin failures++; $display("FAIL seq_valid%0d got=%b exp=1", i, instr_valid); end
            checks++; if (instr_out !== d[i]) begin failures++; $display("FAIL seq_instr%0d got=%h exp=%h", i, instr_out, d[i]); end
            checks++; if (pc_out !== 32'(i * 4)) begin failures++; $display("FAIL seq_pc%0d got=%h exp=%h", i, pc_out, 32'(i * 4)); end
        end
    endtask

    task automatic test_stall;
        bit ok;
        int low;
        do_reset();
        wait_start(20, ok, low);
        stall = 1'b1;
        respond(32'h1111_1111, 3);
        for (int i = 0; i < 10; i++) begin
            checks++;
            if ({instr_valid, start_read, instr_out} !== {1'b1, 1'b0, 32'h1111_1111}) begin
                failures++;
                $display("FAIL stall_hold%0d got=v%b s%b %h exp=v1 s0 11111111", i, instr_valid, start_read, instr_out);
            end
            @(negedge clk);
        end
        stall = 1'b0;
        wait_start(20, ok, low);
        checks++; if (!ok) begin failures++; $display("FAIL stall_release got=timeout exp=start_read"); end
        checks++; if (in_address !== 32'h4) begin failures++; $display("FAIL stall_addr got=%h exp=00000004", in_address); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL stall_consumed got=%b exp=0", instr_valid); end
        respond(32'h2222_2222, 3);
        checks++; if ({pc_out, instr_out} !== {32'h4, 32'h2222_2222}) begin failures++; $display("FAIL stall_next got=%h/%h exp=00000004/22222222", pc_out, instr_out); end
    endtask

    task automatic test_branch_stall;
        bit ok;
        int low;
        do_reset();
        wait_start(20, ok, low);
        stall = 1'b1;
        respond(32'h7777_7777, 2);
        @(negedge clk);
        branch_taken = 1'b1;
        branch_target = 32'h0000_0040;
        @(negedge clk);
        branch_taken = 1'b0;
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL brstall_valid got=%b exp=0", instr_valid); end
        wait_start(20, ok, low);
        checks++; if (in_address !== 32'h40) begin failures++; $display("FAIL brstall_addr got=%h exp=00000040", in_address); end
        stall = 1'b0;
        respond(32'h8888_8888, 3);
        checks++; if (pc_out !== 32'h40) begin failures++; $display("FAIL brstall_pc got=%h exp=00000040", pc_out); end
    endtask

    task automatic test_branch_pending;
        bit ok;
        int low;
        do_reset();
        for (int i = 0; i < 2; i++) begin
            wait_start(20, ok, low);
            respond(32'hA000_0000 + 32'(i), 3);
        end
        wait_start(20, ok, low);
        checks++; if (in_address !== 32'h8) begin failures++; $display("FAIL brpend_addr8 got=%h exp=00000008", in_address); end
        branch_taken = 1'b1;
        branch_target = 32'h0000_0103;
        @(negedge clk);
        branch_taken = 1'b0;
        for (int i = 0; i < 2; i++) begin
            checks++;
            if ({start_read, in_address, instr_valid} !== {1'b1, 32'h8, 1'b0}) begin
                failures++;
                $display("FAIL brpend_hold%0d got=s%b %h v%b exp=s1 00000008 v0", i, start_read, in_address, instr_valid);
            end
            @(negedge clk);
        end
        respond(32'h3333_3333, 1);
        checks++; if ({instr_valid, start_read} !== 2'b00) begin failures++; $display("FAIL brpend_drop got=%b exp=00", {instr_valid, start_read}); end
        wait_start(20, ok, low);
        checks++; if (in_address !== 32'h100) begin failures++; $display("FAIL brpend_target got=%h exp=00000100", in_address); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL brpend_stay_invalid got=%b exp=0", instr_valid); end
        respond(32'h4444_4444, 3);
        checks++; if ({instr_valid, pc_out, instr_out} !== {1'b1, 32'h100, 32'h4444_4444}) begin failures++; $display("FAIL brpend_fetch got=v%b %h %h exp=v1 00000100 44444444", instr_valid, pc_out, instr_out); end
    endtask

    task automatic test_branch_same_cycle;
        bit ok;
        int low;
        do_reset();
        wait_start(20, ok, low);
        fetch_ready = 1'b1;
        fetch_data = 32'hAAAA_AAAA;
        branch_taken = 1'b1;
        branch_target = 32'h0000_0200;
        @(negedge clk);
        fetch_ready = 1'b0;
        branch_taken = 1'b0;
        checks++; if ({instr_valid, start_read} !== 2'b00) begin failures++; $display("FAIL brsame_drop got=%b exp=00", {instr_valid, start_read}); end
        wait_start(20, ok, low);
        checks++; if (in_address !== 32'h200) begin failures++; $display("FAIL brsame_target got=%h exp=00000200", in_address); end
        checks++; if (instr_valid !== 1'b0) begin failures++; $display("FAIL brsame_invalid got=%b exp=0", instr_valid); end
        respond(32'h5555_5555, 3);
        checks++; if ({pc_out, instr_out} !== {32'h200, 32'h5555_5555}) begin failures++; $display("FAIL brsame_fetch got=%h/%h exp=00000200/55555555", pc_out, instr_out); end
    endtask

    task automatic test_wrap;
        bit ok;
        int low;
        do_reset();
        wait_start(20, ok, low);
        branch_taken = 1'b1;
        branch_target = 32'hFFFF_FFFF;
        @(negedge clk);
        branch_taken = 1'b0;
        respond(32'h0BAD_0BAD, 2);
        wait_start(20, ok, low);
        checks++; if (in_address !== 32'hFFFF_FFFC) begin failures++; $display("FAIL wrap_top got=%h exp=fffffffc", in_address); end
        respond(32'h6666_6666, 3);
        checks++; if ({pc_out, instr_out} !== {32'hFFFF_FFFC, 32'h6666_6666}) begin failures++; $display("FAIL wrap_fetch got=%h/%h exp=fffffffc/66666666", pc_out, instr_out); end
        wait_start(20, ok, low);
        checks++; if (in_address !== 32'h0) begin failures++; $display("FAIL wrap_zero got=%h exp=00000000", in_address); end
    endtask

    task automatic test_timeout;
        bit ok;
        int low;
        int high;
        do_reset();
        wait_start(20, ok, low);
`ifdef FETCH_TIMEOUT_EN
        high = 0;
        for (int i = 0; i < 100; i++) begin
            if (start_read !== 1'b1) break;
            high++;
            @(negedge clk);
        end
        checks++; if (high != 8) begin failures++; $display("FAIL tmo_req_cycles got=%0d exp=8", high); end
        checks++; if (fetch_error !== 1'b1) begin failures++; $display("FAIL tmo_error got=%b exp=1", fetch_error); end
        wait_start(20, ok, low);
        checks++; if (in_address !== 32'h0) begin failures++; $display("FAIL tmo_retry_addr got=%h exp=00000000", in_address); end
        checks++; if (fetch_error !== 1'b1) begin failures++; $display("FAIL tmo_sticky got=%b exp=1", fetch_error); end
`else
        high = 0;
        for (int i = 0; i < 1000; i++) begin
            checks++;
            if ({start_read, fetch_error} !== 2'b10) begin
                failures++;
                $display("FAIL notmo_hold cycle=%0d got=%b exp=10", i, {start_read, fetch_error});
                break;
            end
            high++;
            @(negedge clk);
        end
`endif
        fetch_ready = 1'b1;
        fetch_data = 32'h9999_9999;
        @(negedge clk);
        fetch_ready = 1'b0;
        checks++; if ({instr_valid, instr_out} !== {1'b1, 32'h9999_9999}) begin failures++; $display("FAIL tmo_late_fetch got=v%b %h exp=v1 99999999", instr_valid, instr_out); end
    endtask

    initial begin
        test_reset();
        test_sequential();
        test_stall();
        test_branch_stall();
        test_branch_pending();
        test_branch_same_cycle();
        test_wrap();
        test_timeout();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/instr_fetch_sequencer.md
Name: instr_fetch_sequencer

Overview:
- Instruction-fetch sequencer that sits directly upstream of the Avalon-MM instruction master interface.
- Holds the program counter and drives start_read/in_address into the master. Captures read_data when the master pulses ready.
- Presents each fetched word to the decode stage through a single-entry, stall-aware output register.
- Handles branch redirects, including squashing a fetch already in flight.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded at reset.
- PC_STEP, 4, byte increment between sequential fetches.
- GAP_CYCLES, 2, minimum cycles start_read is held low between requests; guarantees the master's 2-flop edge detector re-arms. Legal range 2..15.
- TIMEOUT_CYCLES, 255, REQ-state cycle limit; used only with FETCH_TIMEOUT_EN.

Ports:
- clk, input, 1, system clock; single clock domain.
- reset, input, 1, synchronous, active-high reset.
- fetch_ready, input, 1, one-cycle pulse from the master's ready output.
- fetch_data, input, 32, master's read_data; valid only while fetch_ready=1.
- stall, input, 1, decode not accepting; holds instr_valid/instr_out.
- branch_taken, input, 1, one-cycle redirect request.
- branch_target, input, 32, redirect address; bits [1:0] are forced to 0.
- start_read, output, 1, level request to the master.
- in_address, output, 32, fetch address to the master; registered.
- instr_out, output, 32, fetched instruction.
- pc_out, output, 32, address of instr_out.
- instr_valid, output, 1, instr_out/pc_out valid.
- fetch_busy, output, 1, high in the REQ state.
- fetch_error, output, 1, sticky timeout flag; tied 0 without FETCH_TIMEOUT_EN.

Behaviour:
Interface and reset:
- One clock; reset is synchronous and active-high. Clock and reset ports are clk and reset.
- Reset values: pc=RESET_PC, in_address=RESET_PC, start_read=0, instr_valid=0, instr_out=0, pc_out=0, fetch_error=0, squash=0, state=IDLE.
- Reset asserted mid-REQ drops start_read on the next edge. Any later fetch_ready is ignored while state is not REQ.

States (all exits are registered):
- IDLE: entered for exactly one cycle after reset. Next state is REQ; start_read rises the cycle after.
- REQ:
  - start_read=1 and in_address=pc, held stable until fetch_ready.
  - On fetch_ready with squash=0: instr_out<=fetch_data, pc_out<=pc, instr_valid<=1, pc<=pc+PC_STEP (mod 2^32; 0xFFFF_FFFC wraps to 0), start_read<=0, go to GAP.
  - On fetch_ready with squash=1: data is discarded, squash<=0, pc is unchanged (it already holds the branch target), go to GAP.
- GAP:
  - start_read=0; an internal counter runs for GAP_CYCLES.
  - Exit to REQ when the count completes and (instr_valid=0 or stall=0).
  - Otherwise remain in GAP with start_read=0.

Output register:
- The word is consumed on any cycle with instr_valid=1 and stall=0.
- After consumption, instr_valid<=0 unless a new capture occurs on the same edge.
- Capture can only occur when the register is free or being consumed, because REQ is gated at GAP exit. No overwrite of an unconsumed word is possible.

Branch (branch_taken=1):
- pc<=branch_target & ~3 and instr_valid<=0 on the next edge. Branch overrides stall and overrides consumption.
- In REQ before fetch_ready: squash<=1. start_read stays high and in_address stays unchanged until the master responds, because an Avalon transfer cannot be aborted.
- In REQ on the same cycle as fetch_ready: the data is discarded, go to GAP; the next fetch is at the target.
- In IDLE or GAP: only pc and instr_valid are updated; the GAP count continues.
- A second branch while squash=1: pc takes the newest target; squash stays 1.

Optional Feature:
- Macro: FETCH_TIMEOUT_EN.
- Defined:
  - A counter runs while in REQ; it is cleared on REQ entry.
  - When it reaches TIMEOUT_CYCLES without fetch_ready: start_read<=0, fetch_error<=1 (sticky until reset), squash<=0, go to GAP, then retry at the same pc.
- Not defined: REQ waits indefinitely; fetch_error is constant 0 and no counter logic exists.

Test Plan:
- Reset release, master answers 3 cycles after start_read with 0x11111111, 0x22222222, 0x33333333; stall=0:
  - in_address sequence is 0x0, 0x4, 0x8.
  - instr_out matches with pc_out 0x0/0x4/0x8.
  - start_read is low for at least 2 cycles between requests.
- stall=1 held for 10 cycles after the first capture:
  - instr_valid stays 1 and instr_out stays 0x11111111.
  - No second start_read rise until stall falls.
  - Then the fetch at 0x4 proceeds.
- branch_taken with target 0x00000103 while REQ at 0x8 is pending:
  - start_read stays high and in_address stays 0x8.
  - The returned word is dropped and instr_valid stays 0.
  - The next request is at 0x100, with pc_out=0x100.
- branch_taken on the same cycle as fetch_ready: the data is not presented; the next in_address equals the target.
- pc=0xFFFFFFFC fetch completes: the next in_address is 0x00000000.
- With FETCH_TIMEOUT_EN and TIMEOUT_CYCLES=8, master never answers:
  - start_read falls after 8 REQ cycles and fetch_error=1.
  - The retry is at the same address.
  - Without the macro, start_read stays high for 1000 cycles and fetch_error stays 0.
